// File: rtl/target_sequencer_pkg.sv
// Shared whack-a-box game constants: FSM encoding and screen-select codes,
// also used by the datapath and the VGA screen mux.
package target_sequencer_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PICK = 3'd1;
    localparam logic [2:0] ST_SHOW = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [2:0] MIF_LOBBY = 3'd0;
    localparam logic [2:0] MIF_GAP   = 3'd7;
    localparam logic [2:0] NO_BOX    = 3'd0;

    typedef logic [2:0] box_t;

    // A box id is playable when it is non-zero and within the configured box count.
    function automatic logic box_valid(input box_t b, input int unsigned num_boxes);
        return (b != NO_BOX) && (32'(b) <= num_boxes);
    endfunction

endpackage

// File: rtl/target_sequencer_box_debounce.sv
// Sensor input conditioning: 2-flop synchroniser, stability counter, and a
// one-shot press event that re-arms only after a stable release to NO_BOX.
module box_debounce
    import target_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] box_i,
    output logic       press_o,
    output logic [2:0] press_box_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    box_t          sync1_q, sync2_q, cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        press_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end else if (cand_q == NO_BOX) begin
            armed_d = 1'b1;
        end else if (armed_q) begin
            // Fire once per stable press; holding the box keeps it disarmed.
            press_d = 1'b1;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= NO_BOX;
            sync2_q <= NO_BOX;
            cand_q  <= NO_BOX;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= box_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press_o     = press_q;
    assign press_box_o = cand_q;

endmodule

// File: rtl/target_sequencer.sv
// Whack-a-box round controller: picks a target from the LFSR, shows it, and
// judges debounced sensor presses against it inside a timed window.
module target_sequencer
    import target_sequencer_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES      = 12_500_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int NUM_ROUNDS      = 30,
    parameter int NUM_BOXES       = 6
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start_game,
    input  logic [2:0] lfsr_output,
    input  logic [2:0] box_address,
    output logic [2:0] mif_control_signal,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       wrong_pulse,
    output logic [5:0] round_count,
    output logic       game_over,
    output logic       busy
);
    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    box_t          target_q, target_d, prev_q, prev_d;
    logic [WW-1:0] win_q, win_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [5:0]    round_q, round_d;
    logic          hit_q, hit_d, miss_q, miss_d, wrong_q, wrong_d;
    logic          press;
    box_t          press_box;

    box_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .box_i      (box_address),
        .press_o    (press),
        .press_box_o(press_box)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        prev_d   = prev_q;
        win_d    = win_q;
        gap_d    = gap_q;
        round_d  = round_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        wrong_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_game) begin
                    state_d = ST_PICK;
                    round_d = '0;
                end
            end
            ST_PICK: begin
                // Never repeat the previous target; resample next cycle instead.
                if (box_valid(lfsr_output, NUM_BOXES) && lfsr_output != prev_q) begin
                    target_d = lfsr_output;
                    prev_d   = lfsr_output;
                    win_d    = '0;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                win_d = win_q + WW'(1);
                if (press && press_box == target_q) begin
                    hit_d   = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (win_q == WIN_LAST) begin
                    miss_d  = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (press) begin
                    wrong_d = 1'b1;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    round_d = round_q + 6'd1;
                    state_d = (round_d == 6'(NUM_ROUNDS)) ? ST_DONE : ST_PICK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            target_q <= NO_BOX;
            prev_q   <= NO_BOX;
            win_q    <= '0;
            gap_q    <= '0;
            round_q  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            wrong_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            prev_q   <= prev_d;
            win_q    <= win_d;
            gap_q    <= gap_d;
            round_q  <= round_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            wrong_q  <= wrong_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_PICK, ST_GAP: mif_control_signal = MIF_GAP;
            ST_SHOW:         mif_control_signal = target_q;
            default:         mif_control_signal = MIF_LOBBY;
        endcase
    end

    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign wrong_pulse = wrong_q;
    assign round_count = round_q;
    assign game_over   = (state_q == ST_DONE);
    assign busy        = (state_q == ST_PICK) || (state_q == ST_SHOW) || (state_q == ST_GAP);

endmodule

// File: tb/tb_target_sequencer.sv
// Round-level bench for target_sequencer: table-driven rounds, randomized
// rounds judged by an arithmetic event-timing model, plus reset corner cases.
module tb_target_sequencer;
    localparam int W  = 20;
    localparam int G  = 5;
    localparam int D  = 4;
    localparam int R  = 3;
    localparam int NB = 6;

    logic       clk = 1'b0;
    logic       reset, start_game;
    logic [2:0] lfsr, box;
    logic [2:0] mif;
    logic       hit, miss, wrong, game_over, busy;
    logic [5:0] round_count;

    always #5 clk = ~clk;

    target_sequencer #(
        .WINDOW_CYCLES(W), .GAP_CYCLES(G), .DEBOUNCE_CYCLES(D),
        .NUM_ROUNDS(R), .NUM_BOXES(NB)
    ) dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .start_game        (start_game),
        .lfsr_output       (lfsr),
        .box_address       (box),
        .mif_control_signal(mif),
        .hit_pulse         (hit),
        .miss_pulse        (miss),
        .wrong_pulse       (wrong),
        .round_count       (round_count),
        .game_over         (game_over),
        .busy              (busy)
    );

    // act: 0 hit at o, 1 no press, 2 wrong box at o, 3 wrong then release then hit, 4 glitch + ignored start
    typedef struct {
        logic [3:0][2:0] l;
        int              act;
        int              o;
        logic [2:0]      wb;
        bit              rel;
        logic [2:0]      tgt;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int prev_m = 0;
    int rnd_m = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0][2:0] seq4(input logic [2:0] a, input logic [2:0] b,
                                             input logic [2:0] c, input logic [2:0] d);
        return {d, c, b, a};
    endfunction

    // First lfsr sample in 1..NB that differs from the previous target.
    function automatic int pick_idx(input logic [3:0][2:0] l, input int prev);
        for (int i = 0; i < 4; i++)
            if (l[i] != 3'd0 && int'(l[i]) <= NB && int'(l[i]) != prev) return i;
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mif"}, int'(mif), 0);
        chk({tag, "_hit"}, int'(hit), 0);
        chk({tag, "_miss"}, int'(miss), 0);
        chk({tag, "_wrong"}, int'(wrong), 0);
        chk({tag, "_round"}, int'(round_count), 0);
        chk({tag, "_over"}, int'(game_over), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_start();
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        rnd_m = 0;
        chk("start_mif", int'(mif), 7);
        chk("start_busy", int'(busy), 1);
        chk("start_round", int'(round_count), 0);
        chk("start_over", int'(game_over), 0);
    endtask

    // Entered right after the edge that put the DUT in PICK; leaves right after GAP ends.
    task automatic run_round(input vec_t v);
        int k, ehit, emiss, ewrong, eend, c;
        k = pick_idx(v.l, prev_m);
        if (k < 0) begin
            chk("pick_model_has_target", 0, 1);
            return;
        end
        for (int i = 0; i <= k; i++) begin
            lfsr = v.l[i];
            step();
            chk(i < k ? "mif_pick" : "mif_target", int'(mif), i < k ? 7 : int'(v.tgt));
        end
        prev_m = int'(v.tgt);
        ehit = -1; emiss = -1; ewrong = -1;
        case (v.act)
            0:       ehit = v.o + 8;
            2:       begin ewrong = v.o + 8; emiss = W; end
            3:       begin ewrong = v.o + 8; ehit = v.o + 20; end
            default: emiss = W;
        endcase
        eend = (ehit >= 0) ? ehit : emiss;
        c = 0;
        while (c < eend) begin
            case (v.act)
                0: if (c == v.o) box = v.tgt;
                2: if (c == v.o) box = v.wb;
                3: begin
                    if (c == v.o) box = v.wb;
                    if (c == v.o + 6) box = 3'd0;
                    if (c == v.o + 12) box = v.tgt;
                end
                4: begin
                    if (c == v.o) box = v.tgt;
                    if (c == v.o + 2) box = 3'd0;
                    start_game = (c == 1);
                end
                default: ;
            endcase
            step();
            c++;
            chk("hit", int'(hit), int'(c == ehit));
            chk("miss", int'(miss), int'(c == emiss));
            chk("wrong", int'(wrong), int'(c == ewrong));
            chk("mif_show", int'(mif), c < eend ? int'(v.tgt) : 7);
            chk("busy_show", int'(busy), 1);
        end
        start_game = 1'b0;
        if (v.rel) box = 3'd0;
        for (int j = 1; j <= G; j++) begin
            step();
            chk("gap_round", int'(round_count), j < G ? rnd_m : rnd_m + 1);
            chk("gap_pulses", int'(hit | miss | wrong), 0);
            if (j < G) chk("gap_mif", int'(mif), 7);
        end
        rnd_m++;
        chk("end_over", int'(game_over), int'(rnd_m == R));
        chk("end_mif", int'(mif), rnd_m == R ? 0 : 7);
        chk("end_busy", int'(busy), int'(rnd_m != R));
    endtask

    function automatic logic [2:0] rand_box_except(input int ex);
        int v;
        if (ex == 0) return 3'($urandom_range(1, NB));
        v = int'($urandom_range(1, NB - 1));
        if (v >= ex) v++;
        return 3'(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        logic [2:0] t2;

        tbl[0] = '{seq4(3'd3, 3'd3, 3'd3, 3'd3), 0, 0, 3'd0, 1'b0, 3'd3};
        tbl[1] = '{seq4(3'd0, 3'd7, 3'd3, 3'd4), 1, 0, 3'd0, 1'b1, 3'd4};
        tbl[2] = '{seq4(3'd3, 3'd3, 3'd3, 3'd3), 3, 0, 3'd5, 1'b1, 3'd3};
        tbl[3] = '{seq4(3'd6, 3'd2, 3'd2, 3'd2), 2, 2, 3'd1, 1'b1, 3'd6};
        tbl[4] = '{seq4(3'd6, 3'd0, 3'd1, 3'd1), 4, 4, 3'd0, 1'b1, 3'd1};
        tbl[5] = '{seq4(3'd2, 3'd2, 3'd2, 3'd2), 0, 8, 3'd0, 1'b1, 3'd2};

        reset = 1'b1; start_game = 1'b0; lfsr = 3'd0; box = 3'd0;
        step();
        step();
        check_idle_outputs("reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_idle_outputs("idle");

        for (int i = 0; i < 6; i++) begin
            if (i % R == 0) do_start();
            run_round(tbl[i]);
        end

        for (int g = 0; g < 3; g++) begin
            do_start();
            for (int r = 0; r < R; r++) begin
                for (int i = 0; i < 3; i++) v.l[i] = 3'($urandom_range(0, 7));
                v.l[3] = rand_box_except(prev_m);
                v.tgt  = v.l[pick_idx(v.l, prev_m)];
                v.act  = int'($urandom_range(0, 2));
                v.o    = int'($urandom_range(0, 8));
                v.wb   = rand_box_except(int'(v.tgt));
                v.rel  = 1'b1;
                run_round(v);
            end
        end

        // Reset landing on the same edge as a pending hit, in round 2.
        do_start();
        run_round('{seq4(3'd1, 3'd2, 3'd3, 3'd4), 0, 0, 3'd0, 1'b1,
                    (prev_m == 1) ? 3'd2 : 3'd1});
        t2 = rand_box_except(prev_m);
        lfsr = t2;
        step();
        chk("rst_show_mif", int'(mif), int'(t2));
        box = t2;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        check_idle_outputs("rst_show");
        reset = 1'b0;
        box = 3'd0;
        prev_m = 0;
        for (int i = 0; i < 8; i++) step();
        check_idle_outputs("post_rst");

        // prev_target is cleared by reset, so the last target is accepted immediately.
        do_start();
        run_round('{seq4(t2, t2, t2, t2), 1, 0, 3'd0, 1'b1, t2});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
